// File: rtl/keypad_pkg.sv
// Shared key codes, state encodings and key classification helpers for the
// keypad entry controller and its press qualifier.
package keypad_pkg;

    localparam logic [3:0] KEY_DIGIT_MIN = 4'd1;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'd4;
    localparam logic [3:0] KEY_ENTER     = 4'd5;
    localparam logic [3:0] KEY_CLEAR     = 4'd6;

    typedef logic [1:0] main_state_t;
    localparam main_state_t ST_IDLE   = 2'd0;
    localparam main_state_t ST_ENTRY  = 2'd1;
    localparam main_state_t ST_SUBMIT = 2'd2;

    typedef logic [0:0] qual_state_t;
    localparam qual_state_t QS_ARMED   = 1'b0;
    localparam qual_state_t QS_RELEASE = 1'b1;

    function automatic logic is_digit(input logic [3:0] code);
        return (code >= KEY_DIGIT_MIN) && (code <= KEY_DIGIT_MAX);
    endfunction

    // Codes 0 (multi-key) and 7..15 never count as a press.
    function automatic logic is_key(input logic [3:0] code);
        return (code >= KEY_DIGIT_MIN) && (code <= KEY_CLEAR);
    endfunction

endpackage

// File: rtl/key_qualifier.sv
// Debounces the decoder's key_down/key_code pair and emits exactly one
// key_evt per physical press, then waits for a stable release.
module key_qualifier
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_down,
    input  logic [3:0] key_code,
    output logic       key_evt,
    output logic [3:0] evt_code
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    qual_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       prev_code;
    logic             press_stable;

    // A press only accumulates while the same valid code is seen on
    // consecutive cycles; any change restarts the debounce window.
    assign press_stable = key_down && is_key(key_code) && (key_code == prev_code);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= QS_ARMED;
            cnt       <= '0;
            prev_code <= '0;
            key_evt   <= 1'b0;
            evt_code  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            prev_code <= key_code;
            key_evt   <= 1'b0;
            case (state)
                QS_ARMED: begin
                    if (!press_stable) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        key_evt  <= 1'b1;
                        evt_code <= key_code;
                        cnt      <= '0;
                        state    <= QS_RELEASE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                QS_RELEASE: begin
                    if (key_down) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= QS_ARMED;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= QS_ARMED;
                end
            endcase
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Collects a CODE_LEN-digit code from qualified key presses and hands it to
// the parking FSM over a valid/ready handshake, with clear, error and timeout.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int CODE_LEN        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_down,
    input  logic [3:0]            key_code,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [4*CODE_LEN-1:0] cmd_code,
    output logic [2:0]            digit_count,
    output logic                  busy,
    output logic                  err_pulse,
    output logic                  timeout_pulse
);

    localparam int CODE_W = 4 * CODE_LEN;
    localparam logic [2:0] FULL_COUNT = 3'(CODE_LEN);
    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic              key_evt;
    logic [3:0]        evt_code;
    main_state_t       state;
    logic [IDLE_W-1:0] idle_cnt;
    logic [CODE_W-1:0] code_shifted;
    logic              evt_digit;
    logic              evt_enter;
    logic              evt_clear;

    key_qualifier #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_qualifier (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_down(key_down),
        .key_code(key_code),
        .key_evt (key_evt),
        .evt_code(evt_code)
    );

    // New digit enters at the LS nibble so the first digit ends up MS-most.
    assign code_shifted = CODE_W'(cmd_code << 4) | CODE_W'(evt_code);

    assign evt_digit = key_evt && is_digit(evt_code);
    assign evt_enter = key_evt && (evt_code == KEY_ENTER);
    assign evt_clear = key_evt && (evt_code == KEY_CLEAR);

    assign busy = (state == ST_ENTRY) || (state == ST_SUBMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            idle_cnt      <= '0;
            cmd_valid     <= 1'b0;
            cmd_code      <= '0;
            digit_count   <= '0;
            err_pulse     <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            err_pulse     <= 1'b0;
            timeout_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    idle_cnt <= '0;
                    if (evt_digit) begin
                        cmd_code    <= code_shifted;
                        digit_count <= 3'd1;
                        state       <= ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (key_evt) begin
                        idle_cnt <= '0;
                        if (evt_digit) begin
                            if (digit_count < FULL_COUNT) begin
                                cmd_code    <= code_shifted;
                                digit_count <= digit_count + 3'd1;
                            end else begin
                                err_pulse <= 1'b1;
                            end
                        end else if (evt_enter) begin
                            if (digit_count == FULL_COUNT) begin
                                cmd_valid <= 1'b1;
                                state     <= ST_SUBMIT;
                            end else begin
                                err_pulse <= 1'b1;
                            end
                        end else if (evt_clear) begin
                            cmd_code    <= '0;
                            digit_count <= '0;
                            state       <= ST_IDLE;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        timeout_pulse <= 1'b1;
                        idle_cnt      <= '0;
                        cmd_code      <= '0;
                        digit_count   <= '0;
                        state         <= ST_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                ST_SUBMIT: begin
                    // Key events are dropped here; only the handshake moves on.
                    idle_cnt <= '0;
                    if (cmd_ready) begin
                        cmd_valid   <= 1'b0;
                        cmd_code    <= '0;
                        digit_count <= '0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    idle_cnt    <= '0;
                    cmd_valid   <= 1'b0;
                    cmd_code    <= '0;
                    digit_count <= '0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl: directed scenarios plus a
// randomized key sequence compared against an event-level entry model.
module tb_keypad_entry_ctrl;

    localparam int CODE_LEN = 4;
    localparam int DEB      = 4;
    localparam int TMO      = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_down = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid;
    logic [15:0] cmd_code;
    logic [2:0]  digit_count;
    logic        busy;
    logic        err_pulse;
    logic        timeout_pulse;

    int errors = 0;
    int checks = 0;

    int err_cycles  = 0;
    int to_cycles   = 0;
    int both_cycles = 0;

    // Reference model: 0 idle, 1 collecting digits, 2 waiting for consumer.
    int m_mode = 0;
    int m_digits[$];
    int exp_err = 0;
    int exp_to  = 0;

    keypad_entry_ctrl #(
        .CODE_LEN       (CODE_LEN),
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_down     (key_down),
        .key_code     (key_code),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_code     (cmd_code),
        .digit_count  (digit_count),
        .busy         (busy),
        .err_pulse    (err_pulse),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (err_pulse === 1'b1) err_cycles++;
            if (timeout_pulse === 1'b1) to_cycles++;
            if (err_pulse === 1'b1 && timeout_pulse === 1'b1) both_cycles++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] m_code();
        logic [15:0] v;
        v = 16'h0;
        foreach (m_digits[i]) v = (v << 4) | 16'(m_digits[i]);
        return v;
    endfunction

    function automatic void model_key(input int k);
        if (m_mode == 0) begin
            if (k >= 1 && k <= 4) begin
                m_digits = {k};
                m_mode   = 1;
            end
        end else if (m_mode == 1) begin
            if (k >= 1 && k <= 4) begin
                if (m_digits.size() < CODE_LEN) m_digits.push_back(k);
                else exp_err++;
            end else if (k == 5) begin
                if (m_digits.size() == CODE_LEN) m_mode = 2;
                else exp_err++;
            end else if (k == 6) begin
                m_digits.delete();
                m_mode = 0;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k, input int hold, input int rel);
        key_code = k;
        key_down = 1'b1;
        repeat (hold) tick();
        key_down = 1'b0;
        repeat (rel) tick();
        if (k >= 4'd1 && k <= 4'd6) model_key(int'(k));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({cmd_valid, cmd_code, digit_count, busy, err_pulse, timeout_pulse} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b code=%h count=%0d busy=%b err=%b to=%b required all zero",
                     cmd_valid, cmd_code, digit_count, busy, err_pulse, timeout_pulse);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_bounce();
        key_code = 4'd2;
        for (int i = 0; i < 10; i++) begin
            key_down = ~key_down;
            tick();
        end
        key_down = 1'b0;
        repeat (6) tick();
        checks++;
        if (digit_count !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bounce: got count=%0d busy=%b required count=0 busy=0", digit_count, busy);
        end
    endtask

    task automatic test_entry();
        press(4'd1, 6, 6);
        press(4'd3, 6, 6);
        press(4'd2, 6, 6);
        press(4'd4, 6, 6);
        press(4'd5, 6, 6);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_code !== 16'h1324 || busy !== 1'b1 || digit_count !== 3'd4) begin
            errors++;
            $display("FAIL entry_submit: got valid=%b code=%h busy=%b count=%0d required 1 1324 1 4",
                     cmd_valid, cmd_code, busy, digit_count);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (cmd_valid !== 1'b1 || cmd_code !== 16'h1324) begin
                errors++;
                $display("FAIL entry_hold cycle %0d: got valid=%b code=%h required 1 1324", i, cmd_valid, cmd_code);
            end
        end
        press(4'd2, 6, 6);
        press(4'd6, 6, 6);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_code !== 16'h1324 || err_cycles !== exp_err) begin
            errors++;
            $display("FAIL submit_keys_dropped: got valid=%b code=%h errs=%0d required 1 1324 %0d",
                     cmd_valid, cmd_code, err_cycles, exp_err);
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        m_digits.delete();
        m_mode = 0;
        checks++;
        if (cmd_valid !== 1'b0 || digit_count !== 3'd0 || busy !== 1'b0 || cmd_code !== 16'h0) begin
            errors++;
            $display("FAIL entry_accept: got valid=%b count=%0d busy=%b code=%h required 0 0 0 0000",
                     cmd_valid, digit_count, busy, cmd_code);
        end
    endtask

    task automatic test_short_overflow();
        int e0;
        e0 = err_cycles;
        press(4'd1, 6, 6);
        press(4'd2, 6, 6);
        press(4'd5, 6, 6);
        checks++;
        if (err_cycles - e0 !== 1 || digit_count !== 3'd2) begin
            errors++;
            $display("FAIL short_enter: got err_cycles=%0d count=%0d required 1 2", err_cycles - e0, digit_count);
        end
        press(4'd3, 6, 6);
        press(4'd4, 6, 6);
        checks++;
        if (err_cycles - e0 !== 1 || cmd_code !== 16'h1234 || digit_count !== 3'd4) begin
            errors++;
            $display("FAIL full_code: got err_cycles=%0d code=%h count=%0d required 1 1234 4",
                     err_cycles - e0, cmd_code, digit_count);
        end
        press(4'd1, 6, 6);
        checks++;
        if (err_cycles - e0 !== 2 || cmd_code !== 16'h1234 || digit_count !== 3'd4) begin
            errors++;
            $display("FAIL overflow: got err_cycles=%0d code=%h count=%0d required 2 1234 4",
                     err_cycles - e0, cmd_code, digit_count);
        end
        press(4'd6, 6, 6);
    endtask

    task automatic test_hold_clear();
        press(4'd3, 40, 6);
        checks++;
        if (digit_count !== 3'd1 || cmd_code !== 16'h0003 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_one_digit: got count=%0d code=%h busy=%b required 1 0003 1",
                     digit_count, cmd_code, busy);
        end
        press(4'd6, 6, 6);
        checks++;
        if (digit_count !== 3'd0 || cmd_code !== 16'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear: got count=%0d code=%h busy=%b required 0 0000 0", digit_count, cmd_code, busy);
        end
    endtask

    task automatic test_timeout();
        int n;
        int t0;
        t0 = to_cycles;
        key_code = 4'd4;
        key_down = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_start: got busy=%b required 1", busy);
        end
        n = 0;
        while (timeout_pulse !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (n == 6) key_down = 1'b0;
        end
        key_down = 1'b0;
        checks++;
        if (n !== TMO) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles required %0d", n, TMO);
        end
        checks++;
        if (digit_count !== 3'd0 || busy !== 1'b0 || cmd_code !== 16'h0) begin
            errors++;
            $display("FAIL timeout_clear: got count=%0d busy=%b code=%h required 0 0 0000", digit_count, busy, cmd_code);
        end
        tick();
        exp_to++;
        checks++;
        if (timeout_pulse !== 1'b0 || to_cycles - t0 !== 1) begin
            errors++;
            $display("FAIL timeout_width: got pulse=%b cycles=%0d required 0 1", timeout_pulse, to_cycles - t0);
        end
        repeat (6) tick();
    endtask

    task automatic test_random();
        logic [3:0] k;
        int r;
        for (int step = 0; step < 40; step++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 9);
                k = (r == 0) ? 4'd0 : 4'(6 + r);
                cmd_ready = 1'b1;
                press(k, 6, 6);
                cmd_ready = 1'b0;
            end
            r = $urandom_range(0, 9);
            if (r <= 6) k = 4'($urandom_range(1, 4));
            else if (r <= 8) k = 4'd5;
            else k = 4'd6;
            press(k, 6 + $urandom_range(0, 4), 6);
            checks++;
            if (cmd_valid !== (m_mode == 2) || busy !== (m_mode != 0) ||
                digit_count !== 3'(m_digits.size()) || cmd_code !== m_code() ||
                err_cycles !== exp_err || to_cycles !== exp_to) begin
                errors++;
                $display("FAIL random step %0d key %0d: got valid=%b busy=%b count=%0d code=%h errs=%0d tos=%0d required %b %b %0d %h %0d %0d",
                         step, k, cmd_valid, busy, digit_count, cmd_code, err_cycles, to_cycles,
                         (m_mode == 2), (m_mode != 0), m_digits.size(), m_code(), exp_err, exp_to);
            end
            if (m_mode == 2) begin
                repeat ($urandom_range(0, 5)) begin
                    tick();
                    checks++;
                    if (cmd_valid !== 1'b1 || cmd_code !== m_code()) begin
                        errors++;
                        $display("FAIL random_hold step %0d: got valid=%b code=%h required 1 %h",
                                 step, cmd_valid, cmd_code, m_code());
                    end
                end
                if ($urandom_range(0, 1) == 1) press(4'($urandom_range(1, 6)), 6, 6);
                cmd_ready = 1'b1;
                tick();
                cmd_ready = 1'b0;
                m_digits.delete();
                m_mode = 0;
                checks++;
                if (cmd_valid !== 1'b0 || digit_count !== 3'd0 || err_cycles !== exp_err) begin
                    errors++;
                    $display("FAIL random_accept step %0d: got valid=%b count=%0d errs=%0d required 0 0 %0d",
                             step, cmd_valid, digit_count, err_cycles, exp_err);
                end
            end
        end
        if (m_mode != 0) press(4'd6, 6, 6);
    endtask

    task automatic test_reset_submit();
        press(4'd4, 6, 6);
        press(4'd3, 6, 6);
        press(4'd2, 6, 6);
        press(4'd1, 6, 6);
        press(4'd5, 6, 6);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_code !== 16'h4321) begin
            errors++;
            $display("FAIL pre_reset_submit: got valid=%b code=%h required 1 4321", cmd_valid, cmd_code);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_valid, cmd_code, digit_count, busy, err_pulse, timeout_pulse} !== 23'd0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b code=%h count=%0d busy=%b err=%b to=%b required all zero",
                     cmd_valid, cmd_code, digit_count, busy, err_pulse, timeout_pulse);
        end
        m_digits.delete();
        m_mode = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        press(4'd2, 6, 6);
        checks++;
        if (digit_count !== 3'd1 || cmd_code !== 16'h0002 || busy !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_press: got count=%0d code=%h busy=%b valid=%b required 1 0002 1 0",
                     digit_count, cmd_code, busy, cmd_valid);
        end
        press(4'd6, 6, 6);
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_entry();
        test_short_overflow();
        test_hold_clear();
        test_timeout();
        test_random();
        test_reset_submit();
        checks++;
        if (both_cycles !== 0) begin
            errors++;
            $display("FAIL pulse_overlap: got %0d cycles with both pulses required 0", both_cycles);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Sequences operator keypad input for the parking system. It takes the held key code and the key-down level from the button decoder. It debounces them into single press events and collects a CODE_LEN-digit slot/ticket code. On ENTER it hands the code to the parking FSM over a valid/ready handshake. It also handles clear, short-entry errors, overflow and an inactivity timeout.

Parameters:
CODE_LEN, 4, number of digits in a complete code (1..7)
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles needed to accept a press or a release (10 ms at 100 MHz)
TIMEOUT_CYCLES, 500000000, idle clk cycles in ENTRY before the entry is aborted (5 s)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_down  in  1  high while any tactile switch is held
key_code  in  4  decoder value: 1-4 digit, 5 ENTER, 6 CLEAR, 0 or other invalid
cmd_valid  out  1  completed code available
cmd_ready  in  1  consumer accepts the code
cmd_code  out  4*CODE_LEN  entered digits; first digit in the MS nibble
digit_count  out  3  digits entered so far (0..CODE_LEN)
busy  out  1  high in ENTRY or SUBMIT
err_pulse  out  1  one-cycle error strobe
timeout_pulse  out  1  one-cycle timeout strobe

Behaviour:
- Reset (async, rst_n low) and every output clears: cmd_valid=0, cmd_code=0, digit_count=0, busy=0, both pulses=0. State goes to IDLE and the qualifier goes to ARMED with its counter at 0. Reset mid-entry or mid-handshake discards everything.
- Press qualifier runs every cycle, independent of the main FSM.
  - ARMED: the counter increments while key_down=1 and key_code is in 1..6 and unchanged from the previous cycle. Otherwise the counter is 0.
  - When the counter reaches DEBOUNCE_CYCLES-1, the qualifier issues a one-cycle internal key_evt carrying the latched code and goes to RELEASE.
  - RELEASE: the counter increments while key_down=0 and resets on any key_down=1. At DEBOUNCE_CYCLES-1 it returns to ARMED.
  - Holding a key gives exactly one event. A code of 0 while key_down=1 (multi-key) never qualifies.
- Main FSM. Outputs update on the clk edge after key_evt, so latency from key_evt is 1 cycle.
  - IDLE, digit key: cmd_code <= {cmd_code[4*CODE_LEN-5:0], digit}, digit_count <= 1, go to ENTRY. ENTER or CLEAR in IDLE is ignored.
  - ENTRY, digit key with digit_count<CODE_LEN: shift the digit in and increment digit_count.
  - ENTRY, digit key with digit_count==CODE_LEN: code unchanged, err_pulse=1.
  - ENTRY, ENTER with digit_count==CODE_LEN: go to SUBMIT, cmd_valid=1.
  - ENTRY, ENTER with digit_count<CODE_LEN: err_pulse=1, stay in ENTRY.
  - ENTRY, CLEAR: cmd_code=0, digit_count=0, go to IDLE.
  - ENTRY, timeout: the idle counter clears on every key_evt. When it reaches TIMEOUT_CYCLES-1, timeout_pulse=1, code and count clear, go to IDLE.
  - SUBMIT: cmd_valid and cmd_code hold stable until cmd_ready=1 while cmd_valid=1. On that cycle the transfer completes, and next cycle cmd_valid=0, code and count clear, state IDLE. Key events in SUBMIT are dropped with no error. No timeout runs in SUBMIT.
- cmd_ready while cmd_valid=0 is ignored. cmd_valid never drops without a transfer, except on reset.
- busy=1 in ENTRY and SUBMIT.
- Both pulses are registered and last exactly 1 cycle. err_pulse and timeout_pulse are never asserted together.
- Codes 7..15 never qualify as events.

Decomposition:
- Package keypad_pkg:
  - KEY_ENTER=5, KEY_CLEAR=6, KEY_DIGIT_MAX=4
  - main state encoding IDLE/ENTRY/SUBMIT
  - qualifier state encoding ARMED/RELEASE
- Sub-module key_qualifier (debounce plus one-shot; outputs key_evt and evt_code), instantiated once.
- FSM, shift register and timeout counter live in keypad_entry_ctrl.

Test Plan:
Bench overrides DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50, CODE_LEN=4.
- Bounce: toggle key_down with code 2 at 1-cycle intervals for 10 cycles, then release -> no event, digit_count=0.
- Entry: press 1,3,2,4 (each held 6 cycles, released 6 cycles), then ENTER, cmd_ready=0 -> cmd_valid=1, cmd_code=16'h1324, busy=1, held stable for 20 cycles. Raise cmd_ready for 1 cycle -> next cycle cmd_valid=0, digit_count=0, busy=0.
- Short ENTER and overflow: press 1,2 then ENTER -> err_pulse 1 cycle, digit_count=2. Press 3,4,1 -> err_pulse on the fifth digit, cmd_code=16'h1234.
- Hold and CLEAR: hold key 3 for 40 cycles -> one digit only. Then CLEAR -> digit_count=0, cmd_code=0, state IDLE.
- Timeout: press 4, wait 50 cycles -> timeout_pulse at cycle 50, digit_count=0. Keys pressed during SUBMIT are ignored.
- Reset: assert rst_n=0 asynchronously mid-SUBMIT -> all outputs 0 immediately. A press after release is accepted normally.
